// File: rtl/mesi_pkg.sv
// rtl/mesi_pkg.sv - MESI encodings, coherence-unit FSM states and grant-state helper
package mesi_pkg;

  typedef enum logic [1:0] {
    MESI_M = 2'b00,
    MESI_E = 2'b01,
    MESI_S = 2'b10,
    MESI_I = 2'b11
  } mesi_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_WB,
    ST_FILL,
    ST_RESP
  } ccu_state_t;

  function automatic mesi_t mesi_grant(input logic wr, input logic any_hit);
    if (wr) return MESI_M;
    return any_hit ? MESI_S : MESI_E;
  endfunction

endpackage

// File: rtl/mesi_ccu_rr_arbiter.sv
// rtl/mesi_ccu_rr_arbiter.sv - round-robin arbiter; search starts at the pointer, pointer moves past the winner on advance
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  rot;
  logic [IW:0]   sum;
  logic [IW:0]   nxt;
  logic          found;

  always_comb begin
    rot   = N'({req, req} >> ptr_q);
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (IW+1)'(i);
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        idx   = sum[IW-1:0];
        grant[sum[IW-1:0]] = 1'b1;
      end
    end
    nxt   = {1'b0, idx} + (IW+1)'(1);
    ptr_d = ptr_q;
    if (advance) ptr_d = (nxt == (IW+1)'(N)) ? '0 : nxt[IW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mesi_ccu.sv
// rtl/mesi_ccu.sv - MESI coherence unit: serialises L1 requests, snoops peers, sources data from a sharer or memory
// Optional snoop-ack timeout enabled by defining MESI_CCU_SNOOP_TIMEOUT_EN.
module mesi_ccu import mesi_pkg::*; #(
  parameter int N_CORES     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CORES-1:0]          req_valid,
  input  logic [N_CORES-1:0]          req_wr,
  input  logic [N_CORES*ADDR_W-1:0]   req_addr,
  output logic [N_CORES-1:0]          resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  output logic [1:0]                  resp_state,
  output logic [N_CORES-1:0]          snoop_valid,
  output logic [ADDR_W-1:0]           snoop_addr,
  output logic [1:0]                  snoop_upd,
  input  logic [N_CORES-1:0]          snoop_ack,
  input  logic [N_CORES-1:0]          snoop_hit,
  input  logic [N_CORES-1:0]          snoop_dirty,
  input  logic [N_CORES*DATA_W-1:0]   snoop_data,
  output logic                        mem_req,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        snoop_timeout
);

  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  ccu_state_t                state_q, state_d;
  logic [N_CORES-1:0]        grant_q, grant_d;
  logic [N_CORES-1:0]        ack_q, ack_d;
  logic [N_CORES-1:0]        hit_q, hit_d;
  logic [N_CORES-1:0]        dirty_q, dirty_d;
  logic [N_CORES*DATA_W-1:0] sdata_q, sdata_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      wr_q, wr_d;
  logic [DATA_W-1:0]         rdata_q, rdata_d;
  mesi_t                     rstate_q, rstate_d;

  logic [N_CORES-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               advance;
  logic [N_CORES-1:0] snoop_mask;
  logic [N_CORES-1:0] new_ack;
  logic               all_acked;
  logic               give_up;
  logic               any_hit;
  logic               src_dirty;
  logic [DATA_W-1:0]  src_data;

`ifdef MESI_CCU_SNOOP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout_q, timeout_d;
  assign snoop_timeout = timeout_q;
`else
  assign snoop_timeout = 1'b0;
`endif

  rr_arbiter #(.N(N_CORES)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (advance),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  assign snoop_mask = ~grant_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = ack_q;
    hit_d     = hit_q;
    dirty_d   = dirty_q;
    sdata_d   = sdata_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    rdata_d   = rdata_q;
    rstate_d  = rstate_q;
    advance   = 1'b0;
    new_ack   = snoop_ack & snoop_mask & ~ack_q;
    all_acked = 1'b0;
    give_up   = 1'b0;
    any_hit   = 1'b0;
    src_dirty = 1'b0;
    src_data  = '0;
`ifdef MESI_CCU_SNOOP_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          advance = 1'b1;
          grant_d = arb_grant;
          addr_d  = req_addr[arb_idx*ADDR_W +: ADDR_W];
          wr_d    = req_wr[arb_idx];
          ack_d   = '0;
          hit_d   = '0;
          dirty_d = '0;
          state_d = (N_CORES == 1) ? ST_FILL : ST_SNOOP;
`ifdef MESI_CCU_SNOOP_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      ST_SNOOP: begin
        // Only the first ack of each peer counts; its hit/dirty/data are captured in that cycle.
        ack_d = ack_q | new_ack;
        for (int i = 0; i < N_CORES; i++) begin
          if (new_ack[i]) begin
            hit_d[i]   = snoop_hit[i];
            dirty_d[i] = snoop_dirty[i];
            sdata_d[i*DATA_W +: DATA_W] = snoop_data[i*DATA_W +: DATA_W];
          end
        end
        all_acked = ((ack_d & snoop_mask) == snoop_mask);
`ifdef MESI_CCU_SNOOP_TIMEOUT_EN
        tcnt_d  = tcnt_q + TW'(1);
        give_up = !all_acked && (tcnt_q == TW'(TIMEOUT_CYC - 1));
        if (give_up) timeout_d = 1'b1;
`endif
        if (all_acked || give_up) begin
          // Descending scan so the lowest-index hitting core ends up as the source.
          for (int i = N_CORES - 1; i >= 0; i--) begin
            if (hit_d[i]) begin
              src_dirty = dirty_d[i];
              src_data  = sdata_d[i*DATA_W +: DATA_W];
            end
          end
          any_hit  = |hit_d;
          rstate_d = mesi_grant(wr_q, any_hit);
          rdata_d  = src_data;
          state_d  = !any_hit ? ST_FILL : (src_dirty ? ST_WB : ST_RESP);
        end
      end
      ST_WB: begin
        if (mem_ready) state_d = ST_RESP;
      end
      ST_FILL: begin
        if (mem_ready) begin
          rdata_d  = mem_rdata;
          rstate_d = mesi_grant(wr_q, 1'b0);
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ack_q    <= '0;
      hit_q    <= '0;
      dirty_q  <= '0;
      sdata_q  <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      rstate_q <= MESI_M;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      hit_q    <= hit_d;
      dirty_q  <= dirty_d;
      sdata_q  <= sdata_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      rstate_q <= rstate_d;
    end
  end

`ifdef MESI_CCU_SNOOP_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign snoop_valid = (state_q == ST_SNOOP) ? snoop_mask : '0;
  assign snoop_addr  = (state_q == ST_SNOOP) ? addr_q : '0;
  assign snoop_upd   = (state_q == ST_SNOOP) ? (wr_q ? MESI_I : MESI_S) : 2'b00;
  assign mem_req     = (state_q == ST_WB) || (state_q == ST_FILL);
  assign mem_wr      = (state_q == ST_WB);
  assign mem_addr    = mem_req ? addr_q : '0;
  assign mem_wdata   = (state_q == ST_WB) ? rdata_q : '0;
  assign resp_valid  = (state_q == ST_RESP) ? grant_q : '0;
  assign resp_data   = (state_q == ST_RESP) ? rdata_q : '0;
  assign resp_state  = (state_q == ST_RESP) ? rstate_q : 2'b00;

endmodule

// File: tb/tb_mesi_ccu.sv
// tb/tb_mesi_ccu.sv - table-driven bench for mesi_ccu with a response scoreboard
// Snoop-timeout scenario follows MESI_CCU_SNOOP_TIMEOUT_EN when it is defined.
module tb_mesi_ccu;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_wr;
  logic [N*32-1:0] req_addr;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_data;
  logic [1:0]      resp_state;
  logic [N-1:0]    snoop_valid;
  logic [31:0]     snoop_addr;
  logic [1:0]      snoop_upd;
  logic [N-1:0]    snoop_ack = '0, snoop_hit = '0, snoop_dirty = '0;
  logic [N*32-1:0] snoop_data = '0;
  logic            mem_req, mem_wr;
  logic [31:0]     mem_addr, mem_wdata;
  logic            mem_ready = 1'b0;
  logic [31:0]     mem_rdata = '0;
  logic            snoop_timeout;

  mesi_ccu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_state(resp_state),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_upd(snoop_upd),
    .snoop_ack(snoop_ack), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty), .snoop_data(snoop_data),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .snoop_timeout(snoop_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  hit;
    logic [3:0]  dirty;
    logic [127:0] data;
    int          mlat;
    logic [31:0] mrd;
    logic [3:0]  exp_sv;
    logic [1:0]  exp_upd;
    int          exp_mem;
    logic [31:0] exp_wd;
    logic [31:0] exp_data;
    logic [1:0]  exp_state;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          core;
    logic [31:0] data;
    logic [1:0]  state;
  } exp_t;

  exp_t        sb[$];
  vec_t        vt[7];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mem_cnt = 0;
  logic [3:0]  vhit = '0, vdirty = '0, ack_block = '0;
  logic [127:0] vdata = '0;
  int          mlat = 0;
  logic [31:0] mrdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Peer cores and memory model; grantee junk on snoop_* must be ignored by the DUT.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) snoop_ack[i] = (snoop_valid[i] || vhit[i]) && !ack_block[i];
    snoop_hit   = vhit;
    snoop_dirty = vdirty;
    snoop_data  = vdata;
    if (mem_req) begin
      mem_ready = (mem_cnt == mlat);
      mem_rdata = mrdata;
      mem_cnt++;
    end else begin
      mem_ready = 1'b0;
      mem_cnt   = 0;
    end
  end

  always @(negedge clk) begin
    if (resp_valid != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected resp_valid=%b expected no response", resp_valid);
      end else begin
        exp_t e;
        logic [3:0] oh;
        e  = sb.pop_front();
        oh = 4'b0001 << e.core;
        check("sb_resp_valid", 32'(resp_valid), 32'(oh));
        check("sb_resp_data", resp_data, e.data);
        check("sb_resp_state", 32'(resp_state), 32'(e.state));
      end
    end
  end

  task automatic run_vec(input int n, input vec_t v);
    int          c0, lat, mk;
    bit          done;
    logic [3:0]  sv;
    logic [1:0]  up;
    logic [31:0] sa, ma, mw;
    vhit = v.hit; vdirty = v.dirty; vdata = v.data; mlat = v.mlat; mrdata = v.mrd;
    @(negedge clk);
    req_valid = 4'b0001 << v.core;
    req_wr    = v.wr ? req_valid : 4'b0000;
    req_addr[v.core*32 +: 32] = v.addr;
    sb.push_back('{v.core, v.exp_data, v.exp_state});
    c0 = cyc; lat = 0; mk = 0; done = 1'b0; sv = '0; up = '0; sa = '0; ma = '0; mw = '0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (snoop_valid != '0) begin sv = snoop_valid; up = snoop_upd; sa = snoop_addr; end
      if (mem_req) begin mk = mem_wr ? 2 : 1; ma = mem_addr; mw = mem_wdata; end
      if (resp_valid[v.core]) begin done = 1'b1; lat = cyc - c0; end
    end
    req_valid = '0;
    req_wr    = '0;
    check($sformatf("v%0d_done", n), 32'(done), 32'd1);
    check($sformatf("v%0d_latency", n), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d_snoop_valid", n), 32'(sv), 32'(v.exp_sv));
    check($sformatf("v%0d_snoop_upd", n), 32'(up), 32'(v.exp_upd));
    check($sformatf("v%0d_snoop_addr", n), sa, v.addr);
    check($sformatf("v%0d_mem_kind", n), 32'(mk), 32'(v.exp_mem));
    if (v.exp_mem != 0) check($sformatf("v%0d_mem_addr", n), ma, v.addr);
    if (v.exp_mem == 2) check($sformatf("v%0d_mem_wdata", n), mw, v.exp_wd);
  endtask

  initial begin
    int  c0, lat, served, k;
    bit  done;
    vt[0] = '{0, 1'b0, 32'h100, 4'b0000, 4'b0000, 128'h0, 3, 32'hDEADBEEF,
              4'b1110, 2'b10, 1, 32'h0, 32'hDEADBEEF, 2'b01, 6};
    vt[1] = '{0, 1'b0, 32'h200, 4'b0100, 4'b0000, {32'h0, 32'h1234, 32'h0, 32'h0}, 0, 32'h0,
              4'b1110, 2'b10, 0, 32'h0, 32'h1234, 2'b10, 2};
    vt[2] = '{1, 1'b1, 32'h300, 4'b1000, 4'b1000, {32'hCAFE, 96'h0}, 1, 32'h0,
              4'b1101, 2'b11, 2, 32'hCAFE, 32'hCAFE, 2'b00, 4};
    vt[3] = '{3, 1'b1, 32'h340, 4'b0110, 4'b0000, {32'h0, 32'h22, 32'h11, 32'h0}, 0, 32'h0,
              4'b0111, 2'b11, 0, 32'h0, 32'h11, 2'b00, 2};
    vt[4] = '{2, 1'b0, 32'h380, 4'b1011, 4'b0001, {32'hC3, 32'h0, 32'hB1, 32'hA0}, 0, 32'h0,
              4'b1011, 2'b10, 2, 32'hA0, 32'hA0, 2'b10, 3};
    vt[5] = '{0, 1'b0, 32'h400, 4'b0001, 4'b0001, {96'h0, 32'hBAD0BAD0}, 2, 32'h55AA,
              4'b1110, 2'b10, 1, 32'h0, 32'h55AA, 2'b01, 5};
    vt[6] = '{1, 1'b1, 32'h500, 4'b0000, 4'b0000, 128'h0, 0, 32'h77,
              4'b1101, 2'b11, 1, 32'h0, 32'h77, 2'b00, 3};

    rst = 1'b1; req_valid = '0; req_wr = '0; req_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_state", 32'(resp_state), 32'h0);
    check("rst_snoop_valid", 32'(snoop_valid), 32'h0);
    check("rst_snoop_upd", 32'(snoop_upd), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_snoop_timeout", 32'(snoop_timeout), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // Core2 never acknowledges its snoop.
    vhit = '0; vdirty = '0; vdata = '0; ack_block = 4'b0100; mlat = 0; mrdata = 32'h9999;
    @(negedge clk);
    req_valid = 4'b0001; req_wr = '0; req_addr[31:0] = 32'h700;
    c0 = cyc;
`ifdef MESI_CCU_SNOOP_TIMEOUT_EN
    sb.push_back('{0, 32'h9999, 2'b01});
    done = 1'b0; lat = 0;
    for (k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (k == 10) check("t5_timeout_early", 32'(snoop_timeout), 32'h0);
      if (resp_valid[0]) begin done = 1'b1; lat = cyc - c0; end
    end
    req_valid = '0;
    check("t5_done", 32'(done), 32'd1);
    check("t5_latency", 32'(lat), 32'd66);
    check("t5_timeout_flag", 32'(snoop_timeout), 32'h1);
`else
    repeat (150) @(negedge clk);
    check("t5_stuck_snoop_valid", 32'(snoop_valid), 32'(4'b1110));
    check("t5_stuck_mem_req", 32'(mem_req), 32'h0);
    check("t5_timeout_tied", 32'(snoop_timeout), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
`endif
    ack_block = '0;
    @(negedge clk);

    // Reset while a fill is outstanding: abandoned, no response.
    vhit = '0; mlat = 1000; mrdata = 32'h0;
    @(negedge clk);
    req_valid = 4'b0001; req_addr[31:0] = 32'h600;
    done = 1'b0;
    for (k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (mem_req) done = 1'b1;
    end
    check("t6_fill_reached", 32'(done), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_mem_req_async", 32'(mem_req), 32'h0);
    check("t6_resp_valid_async", 32'(resp_valid), 32'h0);
    check("t6_snoop_valid_async", 32'(snoop_valid), 32'h0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    mlat = 0;
    @(negedge clk);

    // All cores request at once after reset; core0 keeps requesting for a second turn.
    vhit = 4'b1111; vdirty = '0;
    vdata = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
    for (int i = 0; i < N; i++) req_addr[i*32 +: 32] = 32'h800 + 32'(i*4);
    sb.push_back('{0, 32'h1001, 2'b10});
    sb.push_back('{1, 32'h1000, 2'b10});
    sb.push_back('{2, 32'h1000, 2'b10});
    sb.push_back('{3, 32'h1000, 2'b10});
    sb.push_back('{0, 32'h1001, 2'b10});
    @(negedge clk);
    req_valid = 4'b1111; req_wr = '0;
    served = 0;
    for (k = 0; k < 100 && served < 5; k++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        served++;
        if (!(resp_valid[0] && served == 1)) req_valid = req_valid & ~resp_valid;
      end
    end
    req_valid = '0;
    check("t4_served", 32'(served), 32'd5);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
